// File: rtl/gb_apu_frame_sequencer_if.sv
// Frame sequencer control/event bundle: APU power and DIV tap in, channel timing ticks out.
// The master drives the inputs (APU core / bench); the slave is the sequencer.
interface gb_apu_frame_sequencer_if;
  logic       apu_enable;
  logic       div_bit;
  logic       clk_length_ctr;
  logic       clk_sweep;
  logic       clk_vol_env;
  logic [2:0] step;
  logic       length_odd_step;

  modport master (
    output apu_enable,
    output div_bit,
    input  clk_length_ctr,
    input  clk_sweep,
    input  clk_vol_env,
    input  step,
    input  length_odd_step
  );

  modport slave (
    input  apu_enable,
    input  div_bit,
    output clk_length_ctr,
    output clk_sweep,
    output clk_vol_env,
    output step,
    output length_odd_step
  );
endinterface

// File: rtl/gb_apu_frame_sequencer.sv
// Game Boy APU frame sequencer: 512 Hz step source -> length/sweep/envelope enable ticks.
// Define GB_APU_FS_INTERNAL_DIV_EN to replace the DIV tap with an internal CLK_DIV prescaler.
module gb_apu_frame_sequencer #(
  parameter int CLK_DIV = 8192
) (
  input  logic                          clk,
  input  logic                          rst_n,
  gb_apu_frame_sequencer_if.slave       fs
);

  logic [2:0] step_q, step_d;
  logic       len_q, len_d;
  logic       sweep_q, sweep_d;
  logic       env_q, env_d;
  logic       tick;

`ifdef GB_APU_FS_INTERNAL_DIV_EN
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;

  assign tick = fs.apu_enable && (presc_q == PRESC_MAX);

  always_comb begin
    presc_d = '0;
    if (fs.apu_enable && (presc_q != PRESC_MAX)) begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  logic div_prev_q, div_prev_d;

  // div_prev follows div_bit even while powered down, so re-enabling never sees a stale edge.
  assign div_prev_d = fs.div_bit;
  assign tick       = fs.apu_enable && div_prev_q && !fs.div_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_prev_q <= 1'b0;
    end else begin
      div_prev_q <= div_prev_d;
    end
  end
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    step_d  = step_q;
    len_d   = 1'b0;
    sweep_d = 1'b0;
    env_d   = 1'b0;
    if (!fs.apu_enable) begin
      step_d = 3'd0;
    end else if (tick) begin
      len_d   = !step_q[0];                    // steps 0, 2, 4, 6
      sweep_d = step_q[1] && !step_q[0];       // steps 2, 6
      env_d   = (step_q == 3'd7);
      step_d  = step_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q  <= 3'd0;
      len_q   <= 1'b0;
      sweep_q <= 1'b0;
      env_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      step_q  <= step_d;
      len_q   <= len_d;
      sweep_q <= sweep_d;
      env_q   <= env_d;
    end
  end

  assign fs.clk_length_ctr  = len_q;
  assign fs.clk_sweep       = sweep_q;
  assign fs.clk_vol_env     = env_q;
  assign fs.step            = step_q;
  assign fs.length_odd_step = step_q[0];

endmodule

// File: tb/tb_gb_apu_frame_sequencer.sv
// Self-checking bench for gb_apu_frame_sequencer: event-count reference model plus directed
// pulse-count scenarios, with randomized DIV/enable traffic.
module tb_gb_apu_frame_sequencer;

  localparam int TB_CLK_DIV = 4;

  logic clk;
  logic rst_n;

  gb_apu_frame_sequencer_if bus ();

  gb_apu_frame_sequencer #(.CLK_DIV(TB_CLK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fs    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: number of step events since power-up/reset; everything derives from it.
  int m_ev    = 0;
  bit m_prev  = 1'b0;
  int m_presc = 0;
  bit exp_len, exp_sweep, exp_env;

  int cnt_len, cnt_sweep, cnt_env;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ev = 0; m_prev = 1'b0; m_presc = 0;
    exp_len = 1'b0; exp_sweep = 1'b0; exp_env = 1'b0;
  endtask

  task automatic model_edge();
    bit src;
    int pos;
    if (!rst_n) begin
      model_reset();
      return;
    end
`ifdef GB_APU_FS_INTERNAL_DIV_EN
    src = (m_presc == TB_CLK_DIV - 1);
`else
    src = m_prev && !bus.div_bit;
`endif
    m_prev = bus.div_bit;
    exp_len = 1'b0; exp_sweep = 1'b0; exp_env = 1'b0;
    if (!bus.apu_enable) begin
      m_ev = 0;
      m_presc = 0;
    end else begin
      m_presc = (m_presc + 1) % TB_CLK_DIV;
      if (src) begin
        pos       = m_ev % 8;
        exp_len   = (pos % 2 == 0);
        exp_sweep = (pos == 2) || (pos == 6);
        exp_env   = (pos == 7);
        m_ev++;
      end
    end
  endtask

  // One clock: model steps with the DUT at the rising edge, outputs compared mid-cycle.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("step",  {5'd0, bus.step},          8'(m_ev % 8));
    check("odd",   {7'd0, bus.length_odd_step}, 8'((m_ev % 8) % 2));
    check("len",   {7'd0, bus.clk_length_ctr}, {7'd0, exp_len});
    check("sweep", {7'd0, bus.clk_sweep},      {7'd0, exp_sweep});
    check("env",   {7'd0, bus.clk_vol_env},    {7'd0, exp_env});
    cnt_len   += int'(bus.clk_length_ctr);
    cnt_sweep += int'(bus.clk_sweep);
    cnt_env   += int'(bus.clk_vol_env);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_counts();
    cnt_len = 0; cnt_sweep = 0; cnt_env = 0;
  endtask

  task automatic div_fall();
    bus.div_bit = 1'b1;
    cycles($urandom_range(1, 3));
    bus.div_bit = 1'b0;
    cycles($urandom_range(1, 3));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.apu_enable = 1'b0;
    bus.div_bit    = 1'b0;
    model_reset();
    clear_counts();

    cycles(2);
    check("rst_step", {5'd0, bus.step}, 8'd0);
    check("rst_pulses", {5'd0, bus.clk_length_ctr, bus.clk_sweep, bus.clk_vol_env}, 8'd0);
    rst_n = 1'b1;
    cycles(2);

    // 8 falling edges: one full sequence, step wraps back to 0.
    bus.apu_enable = 1'b1;
    cycle();
    clear_counts();
    for (int i = 0; i < 8; i++) div_fall();
`ifndef GB_APU_FS_INTERNAL_DIV_EN
    check("seq8_len",   8'(cnt_len),   8'd4);
    check("seq8_sweep", 8'(cnt_sweep), 8'd2);
    check("seq8_env",   8'(cnt_env),   8'd1);
    check("seq8_step",  {5'd0, bus.step}, 8'd0);
`endif

    // 32 falling edges: four sequences.
    clear_counts();
    for (int i = 0; i < 32; i++) div_fall();
`ifndef GB_APU_FS_INTERNAL_DIV_EN
    check("seq32_len",   8'(cnt_len),   8'd16);
    check("seq32_sweep", 8'(cnt_sweep), 8'd8);
    check("seq32_env",   8'(cnt_env),   8'd4);
`endif

    // DIV held high: no events.
    bus.div_bit = 1'b1;
    cycle();
    clear_counts();
    cycles(1000);
`ifndef GB_APU_FS_INTERNAL_DIV_EN
    check("hold_pulses", 8'(cnt_len + cnt_sweep + cnt_env), 8'd0);
    check("hold_step",   {5'd0, bus.step}, 8'd0);
`endif

    // Power down after 3 events, DIV falls while off, re-enable with DIV already low.
    for (int i = 0; i < 3; i++) div_fall();
    bus.apu_enable = 1'b0;
    cycles(3);
    bus.div_bit = 1'b1;
    cycles(2);
    bus.div_bit = 1'b0;
    cycles(2);
    clear_counts();
    bus.apu_enable = 1'b1;
    cycles(3);
`ifndef GB_APU_FS_INTERNAL_DIV_EN
    check("reen_step",   {5'd0, bus.step}, 8'd0);
    check("reen_pulses", 8'(cnt_len + cnt_sweep + cnt_env), 8'd0);
`endif
    div_fall();
`ifndef GB_APU_FS_INTERNAL_DIV_EN
    check("reen_first_len",   8'(cnt_len),   8'd1);
    check("reen_first_sweep", 8'(cnt_sweep), 8'd0);
    check("reen_first_step",  {5'd0, bus.step}, 8'd1);
`endif

    // Asynchronous reset in the middle of the sequence at step 5.
    for (int i = 0; i < 8 && (m_ev % 8) != 5; i++) div_fall();
`ifndef GB_APU_FS_INTERNAL_DIV_EN
    check("pre_rst_step", {5'd0, bus.step}, 8'd5);
`endif
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_step",   {5'd0, bus.step}, 8'd0);
    check("async_rst_pulses", {5'd0, bus.clk_length_ctr, bus.clk_sweep, bus.clk_vol_env}, 8'd0);
    @(negedge clk);
    cycles(2);
    rst_n = 1'b1;
    clear_counts();
    div_fall();
`ifndef GB_APU_FS_INTERNAL_DIV_EN
    check("post_rst_len",  8'(cnt_len), 8'd1);
    check("post_rst_step", {5'd0, bus.step}, 8'd1);
`endif

    // Randomized DIV toggling and power cycling against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) bus.div_bit = ~bus.div_bit;
      bus.apu_enable = ($urandom_range(0, 39) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
